// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter unit.
package pc_pkg;

  localparam int PC_XLEN = 32;

  typedef enum logic [2:0] {
    PC_SRC_TRAP,
    PC_SRC_HOLD,
    PC_SRC_REDIR,
    PC_SRC_RAS,
    PC_SRC_SEQ
  } pc_src_e;

  // Width of a counter that must hold the values 0..depth inclusive.
  function automatic int ras_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push, pop, push+pop replace of the top, entry count.
module pc_ras
  import pc_pkg::*;
#(
  parameter int XLEN  = PC_XLEN,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_push,
  input  logic                        i_pop,
  input  logic [XLEN-1:0]             i_push_data,
  output logic [XLEN-1:0]             o_top,
  output logic [ras_cnt_w(DEPTH)-1:0] o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = ras_cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [XLEN-1:0] r_stack [DEPTH];
  logic [PW-1:0]   r_ptr;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   w_top_idx;
  logic            w_empty;
  logic            w_replace;
  logic            w_do_push;
  logic            w_do_pop;

  // r_ptr is the next free slot; the top sits just below it and wraps with the pointer.
  assign w_top_idx = r_ptr - PW'(1);
  assign w_empty   = (r_count == '0);
  assign w_replace = i_push & i_pop & ~w_empty;
  assign w_do_push = i_push & ~w_replace;
  assign w_do_pop  = i_pop & ~i_push & ~w_empty;

  // NOTE: the entries carry no reset; r_ptr/r_count alone define which ones are valid.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_stack[r_ptr] <= i_push_data;
    end else if (w_replace) begin
      r_stack[w_top_idx] <= i_push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (w_do_push) begin
      r_ptr <= r_ptr + PW'(1);
      if (r_count != FULL) begin
        r_count <= r_count + CW'(1);
      end
    end else if (w_do_pop) begin
      r_ptr   <= w_top_idx;
      r_count <= r_count - CW'(1);
    end
  end

  assign o_top   = r_stack[w_top_idx];
  assign o_count = r_count;

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: trap, stall, redirect, RAS prediction, sequential step.
// Define PC_RAS_EN to compile in the return-address stack; otherwise call/ret are ignored.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN      = PC_XLEN,
  parameter int              STEP      = 1,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              RAS_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            en,
  input  logic                            trap_valid,
  input  logic [XLEN-1:0]                 trap_vec,
  input  logic                            redirect_valid,
  input  logic [XLEN-1:0]                 redirect_target,
  input  logic                            call,
  input  logic                            ret,
  output logic [XLEN-1:0]                 pc,
  output logic [XLEN-1:0]                 pc_next,
  output logic [ras_cnt_w(RAS_DEPTH)-1:0] ras_count,
  output logic                            ras_underflow
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_seq;
  logic [XLEN-1:0] w_pc_next;
  logic [XLEN-1:0] w_ras_top;
  logic            w_ras_hit;
  pc_src_e         w_src;

  assign w_pc_seq = r_pc + XLEN'(STEP);

`ifdef PC_RAS_EN
  logic                            w_ras_upd;
  logic [ras_cnt_w(RAS_DEPTH)-1:0] w_ras_count;
  logic                            r_underflow;

  // Only an unstalled cycle with no trap or redirect commits a call or return.
  assign w_ras_upd = en & ~trap_valid & ~redirect_valid;
  assign w_ras_hit = ret & (w_ras_count != '0);

  pc_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_ras_upd & call),
    .i_pop       (w_ras_upd & ret),
    .i_push_data (w_pc_seq),
    .o_top       (w_ras_top),
    .o_count     (w_ras_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_underflow <= 1'b0;
    end else begin
      r_underflow <= w_ras_upd & ret & ~call & (w_ras_count == '0);
    end
  end

  assign ras_count     = w_ras_count;
  assign ras_underflow = r_underflow;
`else
  logic w_unused_ras;

  assign w_unused_ras  = call ^ ret;
  assign w_ras_hit     = 1'b0;
  assign w_ras_top     = '0;
  assign ras_count     = '0;
  assign ras_underflow = 1'b0;
`endif

  always_comb begin
    // NOTE: defaults are assigned first so every path drives the outputs and no latch is inferred.
    w_src = PC_SRC_SEQ;
    if (trap_valid) begin
      w_src = PC_SRC_TRAP;
    end else if (!en) begin
      w_src = PC_SRC_HOLD;
    end else if (redirect_valid) begin
      w_src = PC_SRC_REDIR;
    end else if (w_ras_hit) begin
      w_src = PC_SRC_RAS;
    end
  end

  always_comb begin
    w_pc_next = w_pc_seq;
    case (w_src)
      PC_SRC_TRAP:  w_pc_next = trap_vec;
      PC_SRC_HOLD:  w_pc_next = r_pc;
      PC_SRC_REDIR: w_pc_next = redirect_target;
      PC_SRC_RAS:   w_pc_next = w_ras_top;
      default:      w_pc_next = w_pc_seq;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= RESET_VEC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign pc      = r_pc;
  assign pc_next = w_pc_next;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: instance A (STEP=4, RESET_VEC=0x100), instance B (STEP=1).
module tb_pc_unit;

`ifdef PC_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  logic        a_en, a_trap, a_redir, a_call, a_ret;
  logic [31:0] a_trap_vec, a_target, a_pc, a_pc_next;
  logic [2:0]  a_cnt;
  logic        a_uf;

  logic        b_en, b_trap, b_redir, b_call, b_ret;
  logic [31:0] b_trap_vec, b_target, b_pc, b_pc_next;
  logic [2:0]  b_cnt;
  logic        b_uf;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_unit #(.XLEN(32), .STEP(4), .RESET_VEC(32'h100), .RAS_DEPTH(4)) dut_a (
    .clk(clk), .reset(reset), .en(a_en), .trap_valid(a_trap), .trap_vec(a_trap_vec),
    .redirect_valid(a_redir), .redirect_target(a_target), .call(a_call), .ret(a_ret),
    .pc(a_pc), .pc_next(a_pc_next), .ras_count(a_cnt), .ras_underflow(a_uf)
  );

  pc_unit #(.XLEN(32), .STEP(1), .RESET_VEC(32'h0), .RAS_DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .en(b_en), .trap_valid(b_trap), .trap_vec(b_trap_vec),
    .redirect_valid(b_redir), .redirect_target(b_target), .call(b_call), .ret(b_ret),
    .pc(b_pc), .pc_next(b_pc_next), .ras_count(b_cnt), .ras_underflow(b_uf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    a_en = 1'b1; a_trap = 1'b0; a_redir = 1'b0; a_call = 1'b0; a_ret = 1'b0;
    a_trap_vec = '0; a_target = '0;
    b_en = 1'b1; b_trap = 1'b0; b_redir = 1'b0; b_call = 1'b0; b_ret = 1'b0;
    b_trap_vec = '0; b_target = '0;
    #2;
    check("rst_pc", a_pc, 32'h100);
    check("rst_cnt", a_cnt, 0);
    check("rst_uf", a_uf, 0);

    @(negedge clk); reset = 1'b0;
    tick(); check("run1", a_pc, 32'h104);
    tick(); check("run2", a_pc, 32'h108);

    // Asynchronous reset mid-run, away from any edge.
    #2; reset = 1'b1; #1;
    check("async_rst", a_pc, 32'h100);
    @(negedge clk); reset = 1'b0; #1;
    check("seq_next", a_pc_next, 32'h104);
    tick(); check("seq1", a_pc, 32'h104);
    tick(); check("seq2", a_pc, 32'h108);
    tick(); check("seq3", a_pc, 32'h10C);

    a_en = 1'b0; #1;
    check("stall_next", a_pc_next, 32'h10C);
    tick(); check("stall1", a_pc, 32'h10C);
    tick(); check("stall2", a_pc, 32'h10C);

    a_trap = 1'b1; a_trap_vec = 32'h80; #1;
    check("trap_next", a_pc_next, 32'h80);
    tick(); check("trap_pc", a_pc, 32'h80);
    a_trap = 1'b0; a_en = 1'b1;

    a_trap = 1'b1; a_trap_vec = 32'h200; a_call = 1'b1;
    tick(); check("trap_call_pc", a_pc, 32'h200); check("trap_call_cnt", a_cnt, 0);
    a_trap = 1'b0;
    a_en = 1'b0;
    tick(); check("stall_call_pc", a_pc, 32'h200); check("stall_call_cnt", a_cnt, 0);
    a_en = 1'b1; a_call = 1'b0;

    // Call at 0x10 pushes 0x14, return from 0x14 lands on 0x14.
    a_redir = 1'b1; a_target = 32'h10;
    tick(); check("redir_pc", a_pc, 32'h10);
    a_redir = 1'b0; a_call = 1'b1; #1;
    check("call_next", a_pc_next, 32'h14);
    tick(); check("call_pc", a_pc, 32'h14); check("call_cnt", a_cnt, RAS ? 1 : 0);
    a_call = 1'b0; a_ret = 1'b1; #1;
    check("ret_next", a_pc_next, RAS ? 32'h14 : 32'h18);
    tick(); check("ret_pc", a_pc, RAS ? 32'h14 : 32'h18); check("ret_cnt", a_cnt, 0);
    a_ret = 1'b0;

    // Redirect beats ret; the RAS entry 0x20 must survive.
    a_redir = 1'b1; a_target = 32'h1C;
    tick(); a_redir = 1'b0; a_call = 1'b1;
    tick(); check("prio_call_pc", a_pc, 32'h20); check("prio_call_cnt", a_cnt, RAS ? 1 : 0);
    a_call = 1'b0; a_redir = 1'b1; a_target = 32'h40; a_ret = 1'b1;
    tick(); check("prio_pc", a_pc, 32'h40); check("prio_cnt", a_cnt, RAS ? 1 : 0);
    a_redir = 1'b0;
    tick(); check("prio_ret_pc", a_pc, RAS ? 32'h20 : 32'h44); check("prio_ret_cnt", a_cnt, 0);
    a_ret = 1'b0;

    // Five nested calls into a four-deep stack, then four returns newest first.
    a_redir = 1'b1; a_target = 32'h1000;
    tick(); a_redir = 1'b0; a_call = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("ovf_pc", a_pc, 32'h1014); check("ovf_cnt", a_cnt, RAS ? 4 : 0);
    a_call = 1'b0; a_ret = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ovf_ret_pc", a_pc, RAS ? 32'h1014 - 32'(4 * i) : 32'h1018 + 32'(4 * i));
      check("ovf_ret_cnt", a_cnt, RAS ? 3 - i : 0);
      check("ovf_ret_uf", a_uf, 0);
    end
    a_ret = 1'b0;

    // call+ret replaces the top; on an empty stack it acts as a plain push.
    a_redir = 1'b1; a_target = 32'h2000;
    tick(); a_redir = 1'b0; a_call = 1'b1;
    tick(); check("rep_call_pc", a_pc, 32'h2004); check("rep_call_cnt", a_cnt, RAS ? 1 : 0);
    a_ret = 1'b1;
    tick(); check("rep_pc", a_pc, RAS ? 32'h2004 : 32'h2008); check("rep_cnt", a_cnt, RAS ? 1 : 0);
    a_call = 1'b0;
    tick(); check("rep_ret_pc", a_pc, RAS ? 32'h2008 : 32'h200C); check("rep_ret_cnt", a_cnt, 0);
    a_call = 1'b1;
    tick(); check("empty_cr_pc", a_pc, RAS ? 32'h200C : 32'h2010);
    check("empty_cr_cnt", a_cnt, RAS ? 1 : 0); check("empty_cr_uf", a_uf, 0);
    a_call = 1'b0; a_ret = 1'b0;

    // Underflow on an empty stack (STEP=1) and address wrap.
    b_redir = 1'b1; b_target = 32'h8;
    tick(); check("b_redir_pc", b_pc, 32'h8);
    b_redir = 1'b0; b_ret = 1'b1;
    tick(); check("uf_pc", b_pc, 32'h9); check("uf_pulse", b_uf, RAS ? 1 : 0); check("uf_cnt", b_cnt, 0);
    b_ret = 1'b0;
    tick(); check("uf_clear", b_uf, 0); check("uf_seq_pc", b_pc, 32'hA);
    b_redir = 1'b1; b_target = 32'hFFFF_FFFF;
    tick(); check("wrap_top", b_pc, 32'hFFFF_FFFF);
    b_redir = 1'b0; #1;
    check("wrap_next", b_pc_next, 32'h0);
    tick(); check("wrap_pc", b_pc, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
